// File: rtl/float_rounder.sv
// Back-end rounding stage of the single-precision FPU: denormalizes tiny results,
// applies the rounding mode, detects overflow/underflow and packs the IEEE-754 word.
module float_rounder (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        valid_out,
   input  logic        ready_in,
   input  logic [23:0] man_in,
   input  logic [9:0]  exp_in,
   input  logic        sgn_in,
   input  logic        round_bit,
   input  logic        sticky_bit,
   input  logic        skip_round,
   input  logic        IV_in,
   input  logic [2:0]  rm,
   output logic [31:0] float_out,
   output logic        IV,
   output logic        OF,
   output logic        UF,
   output logic        NX
);

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DENORM = 2'd1,
      ROUND  = 2'd2,
      PACK   = 2'd3
   } state_t;

   state_t             state;
   logic [23:0]        man;
   logic signed [9:0]  exp;
   logic               sgn;
   logic               rb;
   logic               sb;
   logic               skip;
   logic               iv;
   logic [2:0]         rmode;
   logic               tiny;
   logic               nx;
   logic               uf;

   logic               accept;
   logic               den_active;
   logic [10:0]        sh_full;
   logic [4:0]         sh;
   logic [51:0]        wide;
   logic [23:0]        den_man;
   logic               den_r;
   logic               den_s;
   logic               inc;
   logic [24:0]        sum;
   logic               ovf;
   logic               to_inf;
   logic [31:0]        packed_word;

   // Handshake: a new operand is taken only while idle and downstream is ready.
   always_comb begin
      ready_out = ready_in && (state == IDLE);
      accept    = valid_in && ready_out;
   end

   // Denormalization shifter; everything shifted below the round bit folds into sticky.
   always_comb begin
      den_active = (exp[9] || (exp == 10'sd0)) && (man != 24'd0);
      sh_full    = 11'd1 - {exp[9], exp};
      if (sh_full > 11'd26) begin
         sh = 5'd26;
      end else begin
         sh = sh_full[4:0];
      end
      wide    = {man, rb, sb, 26'd0} >> sh;
      den_man = wide[51:28];
      den_r   = wide[27];
      den_s   = wide[26] | (|wide[25:0]);
   end

   // Rounding increment; unused rm encodings fall back to round-to-nearest-even.
   always_comb begin
      case (rmode)
         RM_RNE:  inc = rb & (sb | man[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = (rb | sb) & sgn;
         RM_RUP:  inc = (rb | sb) & ~sgn;
         RM_RMM:  inc = rb;
         default: inc = rb & (sb | man[0]);
      endcase
      sum = {1'b0, man} + {24'd0, inc};
   end

   // Overflow result selection: infinity or largest finite depending on direction.
   always_comb begin
      ovf = (exp >= 10'sd255);
      case (rmode)
         RM_RTZ:  to_inf = 1'b0;
         RM_RDN:  to_inf = sgn;
         RM_RUP:  to_inf = ~sgn;
         default: to_inf = 1'b1;
      endcase
      if (ovf) begin
         if (to_inf) begin
            packed_word = {sgn, 8'hff, 23'h000000};
         end else begin
            packed_word = {sgn, 8'hfe, 23'h7fffff};
         end
      end else begin
         packed_word = {sgn, exp[7:0], man[22:0]};
      end
   end

   // Pipeline sequencer with registered result and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         man       <= 24'd0;
         exp       <= 10'sd0;
         sgn       <= 1'b0;
         rb        <= 1'b0;
         sb        <= 1'b0;
         skip      <= 1'b0;
         iv        <= 1'b0;
         rmode     <= 3'd0;
         tiny      <= 1'b0;
         nx        <= 1'b0;
         uf        <= 1'b0;
         valid_out <= 1'b0;
         float_out <= 32'd0;
         IV        <= 1'b0;
         OF        <= 1'b0;
         UF        <= 1'b0;
         NX        <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         man       <= 24'd0;
         exp       <= 10'sd0;
         sgn       <= 1'b0;
         rb        <= 1'b0;
         sb        <= 1'b0;
         skip      <= 1'b0;
         iv        <= 1'b0;
         rmode     <= 3'd0;
         tiny      <= 1'b0;
         nx        <= 1'b0;
         uf        <= 1'b0;
         valid_out <= 1'b0;
         float_out <= 32'd0;
         IV        <= 1'b0;
         OF        <= 1'b0;
         UF        <= 1'b0;
         NX        <= 1'b0;
      end else if (accept) begin
         man       <= man_in;
         exp       <= $signed(exp_in);
         sgn       <= sgn_in;
         rb        <= round_bit;
         sb        <= sticky_bit;
         skip      <= skip_round;
         iv        <= IV_in;
         rmode     <= rm;
         tiny      <= 1'b0;
         nx        <= 1'b0;
         uf        <= 1'b0;
         valid_out <= 1'b0;
         float_out <= 32'd0;
         IV        <= 1'b0;
         OF        <= 1'b0;
         UF        <= 1'b0;
         NX        <= 1'b0;
         state     <= skip_round ? PACK : DENORM;
      end else begin
         case (state)
            IDLE: begin
               if (valid_out && ready_in) begin
                  valid_out <= 1'b0;
                  float_out <= 32'd0;
                  IV        <= 1'b0;
                  OF        <= 1'b0;
                  UF        <= 1'b0;
                  NX        <= 1'b0;
               end
            end
            DENORM: begin
               if (den_active) begin
                  man  <= den_man;
                  rb   <= den_r;
                  sb   <= den_s;
                  exp  <= 10'sd0;
                  tiny <= 1'b1;
               end else begin
                  tiny <= 1'b0;
               end
               state <= ROUND;
            end
            ROUND: begin
               if (sum[24]) begin
                  man <= 24'h800000;
                  exp <= exp + 10'sd1;
               end else begin
                  man <= sum[23:0];
                  // A subnormal that rounds up into the hidden bit becomes the smallest normal.
                  if ((exp == 10'sd0) && sum[23]) begin
                     exp <= 10'sd1;
                  end
               end
               nx    <= rb | sb;
               uf    <= tiny & (rb | sb);
               state <= PACK;
            end
            PACK: begin
               if (skip) begin
                  float_out <= {sgn, exp[7:0], man[22:0]};
                  IV        <= iv;
                  OF        <= 1'b0;
                  UF        <= 1'b0;
                  NX        <= 1'b0;
               end else begin
                  float_out <= packed_word;
                  IV        <= iv;
                  OF        <= ovf;
                  UF        <= uf;
                  NX        <= ovf | nx;
               end
               valid_out <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_rounder.sv
// Self-checking bench for float_rounder: directed cases, handshake/flush scenarios
// and randomized operands against an arithmetic rounding model.
module tb_float_rounder;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        valid_in;
   logic        ready_out;
   logic        valid_out;
   logic        ready_in;
   logic [23:0] man_in;
   logic [9:0]  exp_in;
   logic        sgn_in;
   logic        round_bit;
   logic        sticky_bit;
   logic        skip_round;
   logic        IV_in;
   logic [2:0]  rm;
   logic [31:0] float_out;
   logic        IV;
   logic        OF;
   logic        UF;
   logic        NX;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] RNE = 3'd0;
   localparam logic [2:0] RTZ = 3'd1;
   localparam logic [2:0] RDN = 3'd2;
   localparam logic [2:0] RUP = 3'd3;
   localparam logic [2:0] RMM = 3'd4;

   float_rounder dut (
      .clk(clk), .reset(reset), .flush(flush),
      .valid_in(valid_in), .ready_out(ready_out),
      .valid_out(valid_out), .ready_in(ready_in),
      .man_in(man_in), .exp_in(exp_in), .sgn_in(sgn_in),
      .round_bit(round_bit), .sticky_bit(sticky_bit),
      .skip_round(skip_round), .IV_in(IV_in), .rm(rm),
      .float_out(float_out), .IV(IV), .OF(OF), .UF(UF), .NX(NX)
   );

   always #5 clk = ~clk;

   // Reference: exact value m.rs * 2^(e-150), rounded on the grid 2^(max(e,1)-150).
   function automatic void model(input logic [23:0] m, input logic [9:0] e, input logic sg,
                                 input logic r, input logic s, input logic [2:0] mode,
                                 output logic [31:0] f, output logic [3:0] fl);
      int     ee;
      int     shv;
      longint scaled;
      longint d;
      longint q;
      longint rem;
      longint half;
      logic   up;
      logic   inexact;
      logic   to_inf;
      ee     = int'($signed(e));
      shv    = (ee <= 0) ? (((1 - ee) > 40) ? 40 : (1 - ee)) : 0;
      // Sticky is weighted below any real bit so it never fakes an exact tie.
      scaled = longint'(m) * 8 + (r ? 4 : 0) + (s ? 1 : 0);
      d      = longint'(8) << shv;
      q      = scaled / d;
      rem    = scaled % d;
      half   = d / 2;
      inexact = (rem != 0);
      case (mode)
         RTZ:     up = 1'b0;
         RDN:     up = inexact && sg;
         RUP:     up = inexact && !sg;
         RMM:     up = (rem >= half);
         default: up = (rem > half) || ((rem == half) && ((q % 2) == 1));
      endcase
      q = q + (up ? 1 : 0);
      if (ee <= 0) begin
         f  = {sg, 31'(q)};
         fl = {2'b00, inexact, inexact};
      end else begin
         if (q == (longint'(1) << 24)) begin
            q  = longint'(1) << 23;
            ee = ee + 1;
         end
         if (ee >= 255) begin
            to_inf = (mode == RTZ) ? 1'b0 : (mode == RDN) ? sg : (mode == RUP) ? !sg : 1'b1;
            f  = to_inf ? {sg, 31'h7f800000} : {sg, 31'h7f7fffff};
            fl = 4'b0101;
         end else begin
            f  = {sg, 8'(ee), 23'(q)};
            fl = {3'b000, inexact};
         end
      end
   endfunction

   task automatic do_op(input logic [23:0] m, input logic [9:0] e, input logic sg,
                        input logic r, input logic s, input logic skip, input logic ivi,
                        input logic [2:0] mode,
                        output logic [31:0] f, output logic [3:0] fl, output int lat);
      int guard;
      guard = 0;
      while (!ready_out && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      man_in = m; exp_in = e; sgn_in = sg; round_bit = r; sticky_bit = s;
      skip_round = skip; IV_in = ivi; rm = mode; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!valid_out) lat = -1;
      f  = float_out;
      fl = {IV, OF, UF, NX};
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      man_in = 24'd0; exp_in = 10'd0; sgn_in = 1'b0; round_bit = 1'b0; sticky_bit = 1'b0;
      skip_round = 1'b0; IV_in = 1'b0; rm = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (valid_out !== 1'b0 || float_out !== 32'd0 || {IV, OF, UF, NX} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%b f=%h fl=%b want v=0 f=0 fl=0000",
                  valid_out, float_out, {IV, OF, UF, NX});
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 1", ready_out);
      end
   endtask

   typedef struct packed {
      logic [23:0] m;
      logic [9:0]  e;
      logic        sg;
      logic        r;
      logic        s;
      logic [2:0]  mode;
      logic [31:0] f;
      logic [3:0]  fl;
   } vec_t;

   task automatic test_directed();
      vec_t        v [7];
      logic [31:0] f;
      logic [3:0]  fl;
      int          lat;
      v[0] = '{24'h800000, 10'd127,  1'b0, 1'b1, 1'b0, RNE, 32'h3f800000, 4'b0001};
      v[1] = '{24'hffffff, 10'd127,  1'b0, 1'b1, 1'b1, RNE, 32'h40000000, 4'b0001};
      v[2] = '{24'h800000, 10'd300,  1'b0, 1'b0, 1'b0, RTZ, 32'h7f7fffff, 4'b0101};
      v[3] = '{24'h800000, 10'd300,  1'b0, 1'b0, 1'b0, RNE, 32'h7f800000, 4'b0101};
      v[4] = '{24'h800000, 10'd300,  1'b1, 1'b0, 1'b0, RUP, 32'hff7fffff, 4'b0101};
      v[5] = '{24'h800000, 10'h3ff,  1'b0, 1'b0, 1'b0, RNE, 32'h00200000, 4'b0000};
      v[6] = '{24'h800000, 10'h3ff,  1'b0, 1'b0, 1'b1, RNE, 32'h00200000, 4'b0011};
      for (int i = 0; i < 7; i++) begin
         do_op(v[i].m, v[i].e, v[i].sg, v[i].r, v[i].s, 1'b0, 1'b0, v[i].mode, f, fl, lat);
         n_checks++;
         if (f !== v[i].f || fl !== v[i].fl || lat != 4) begin
            n_fail++;
            $display("FAIL directed_%0d got f=%h fl=%b lat=%0d want f=%h fl=%b lat=4",
                     i, f, fl, lat, v[i].f, v[i].fl);
         end
      end
   endtask

   task automatic test_special();
      logic [31:0] f;
      logic [3:0]  fl;
      int          lat;
      do_op(24'hc00000, 10'h0ff, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, RNE, f, fl, lat);
      n_checks++;
      if (f !== 32'h7fc00000 || fl !== 4'b1000 || lat != 2) begin
         n_fail++;
         $display("FAIL special_nan got f=%h fl=%b lat=%0d want f=7fc00000 fl=1000 lat=2",
                  f, fl, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] f;
      logic [31:0] ef;
      logic [3:0]  fl;
      logic [3:0]  efl;
      logic [23:0] m;
      logic [9:0]  e;
      logic        sg;
      logic        r;
      logic        s;
      logic [2:0]  mode;
      int          lat;
      for (int i = 0; i < 300; i++) begin
         m    = {1'b1, 23'($urandom)};
         if ($urandom_range(0, 3) == 0) m[22:0] = 23'h7fffff;
         case ($urandom_range(0, 2))
            0:       e = 10'($signed(-$urandom_range(0, 40)));
            1:       e = 10'($urandom_range(240, 300));
            default: e = 10'($urandom_range(1, 254));
         endcase
         sg   = 1'($urandom);
         r    = 1'($urandom);
         s    = 1'($urandom);
         mode = 3'($urandom_range(0, 7));
         model(m, e, sg, r, s, mode, ef, efl);
         do_op(m, e, sg, r, s, 1'b0, 1'b0, mode, f, fl, lat);
         n_checks++;
         if (f !== ef || fl !== efl || lat != 4) begin
            n_fail++;
            $display("FAIL random_%0d m=%h e=%h sg=%b r=%b s=%b rm=%0d got f=%h fl=%b lat=%0d want f=%h fl=%b lat=4",
                     i, m, e, sg, r, s, mode, f, fl, lat, ef, efl);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ef;
      logic [31:0] held;
      logic [3:0]  efl;
      int          lat;
      model(24'h9abcde, 10'd100, 1'b1, 1'b1, 1'b1, RUP, ef, efl);
      while (!ready_out) begin @(posedge clk); #1; end
      man_in = 24'h9abcde; exp_in = 10'd100; sgn_in = 1'b1; round_bit = 1'b1;
      sticky_bit = 1'b1; skip_round = 1'b0; IV_in = 1'b0; rm = RUP; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      ready_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      held = float_out;
      n_checks++;
      if (valid_out !== 1'b1 || ready_out !== 1'b0 || float_out !== ef) begin
         n_fail++;
         $display("FAIL bp_result got v=%b rdy=%b f=%h want v=1 rdy=0 f=%h",
                  valid_out, ready_out, float_out, ef);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (valid_out !== 1'b1 || ready_out !== 1'b0 || float_out !== held || {IV, OF, UF, NX} !== efl) begin
         n_fail++;
         $display("FAIL bp_hold got v=%b rdy=%b f=%h fl=%b want v=1 rdy=0 f=%h fl=%b",
                  valid_out, ready_out, float_out, {IV, OF, UF, NX}, held, efl);
      end
      model(24'h800001, 10'd5, 1'b0, 1'b1, 1'b0, RNE, ef, efl);
      man_in = 24'h800001; exp_in = 10'd5; sgn_in = 1'b0; round_bit = 1'b1;
      sticky_bit = 1'b0; rm = RNE; valid_in = 1'b1; ready_in = 1'b1;
      #1;
      n_checks++;
      if (ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready got %b want 1", ready_out);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      n_checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept got v=%b rdy=%b want v=0 rdy=0", valid_out, ready_out);
      end
      lat = 1;
      while (!valid_out && lat < 10) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (float_out !== ef || {IV, OF, UF, NX} !== efl || lat != 4) begin
         n_fail++;
         $display("FAIL bp_second got f=%h fl=%b lat=%0d want f=%h fl=%b lat=4",
                  float_out, {IV, OF, UF, NX}, lat, ef, efl);
      end
   endtask

   task automatic test_flush();
      int seen;
      while (!ready_out) begin @(posedge clk); #1; end
      man_in = 24'hc00000; exp_in = 10'd130; sgn_in = 1'b0; round_bit = 1'b1;
      sticky_bit = 1'b1; skip_round = 1'b0; IV_in = 1'b0; rm = RNE; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0 || float_out !== 32'd0) begin
         n_fail++;
         $display("FAIL flush_idle got rdy=%b v=%b f=%h want rdy=1 v=0 f=0",
                  ready_out, valid_out, float_out);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (valid_out) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL flush_discard got %0d valid cycles want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_backpressure();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
